// File: rtl/tl_sram_adapter.sv
// tl_sram_adapter: TileLink-UH slave terminating A/D and servicing Get/Put bursts
// from a single-port synchronous SRAM; out-of-window or unsupported requests get denied responses.
module tl_sram_adapter #(
  parameter int SourceWidth = 1,
  parameter int SinkWidth = 1,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64,
  parameter int SizeWidth = 3,
  parameter int MemAddrWidth = 10,
  parameter logic [AddrWidth-1:0] BaseAddr = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [2:0]              a_opcode_i,
  input  logic [2:0]              a_param_i,
  input  logic [SizeWidth-1:0]    a_size_i,
  input  logic [SourceWidth-1:0]  a_source_i,
  input  logic [AddrWidth-1:0]    a_address_i,
  input  logic [DataWidth/8-1:0]  a_mask_i,
  input  logic                    a_corrupt_i,
  input  logic [DataWidth-1:0]    a_data_i,
  output logic                    d_valid_o,
  input  logic                    d_ready_i,
  output logic [2:0]              d_opcode_o,
  output logic [1:0]              d_param_o,
  output logic [SizeWidth-1:0]    d_size_o,
  output logic [SourceWidth-1:0]  d_source_o,
  output logic [SinkWidth-1:0]    d_sink_o,
  output logic                    d_denied_o,
  output logic                    d_corrupt_o,
  output logic [DataWidth-1:0]    d_data_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_wmask_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);
  localparam int LDB = $clog2(DataWidth/8);
  localparam int WB = MemAddrWidth + LDB;
  localparam int BW = 2**SizeWidth;
  localparam logic [SizeWidth-1:0] LDBS = SizeWidth'(LDB);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;
  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [SizeWidth-1:0] size_q, size_d;
  logic [SourceWidth-1:0] src_q, src_d;
  logic [MemAddrWidth-1:0] base_q, base_d;
  logic den_q, den_d;
  logic [BW-1:0] last_q, last_d, beat_q, beat_d, rsp_q, rsp_d;
  logic [1:0][DataWidth-1:0] fifo_q, fifo_d;
  logic wp_q, wp_d, rp_q, rp_d, infl_q, infl_d;
  logic [1:0] cnt_q, cnt_d;
  logic a_den, data_ack, issue, pop, unused_w;
  logic [BW-1:0] a_last, rlast;
  logic [MemAddrWidth-1:0] a_widx;
  // opcodes 0,1,4,5 are exactly those with bit 1 clear; the window is aligned so only upper bits matter
  assign a_den = (a_address_i[AddrWidth-1:WB] != BaseAddr[AddrWidth-1:WB]) || a_opcode_i[1];
  assign a_last = (a_size_i > LDBS) ? (BW'(1) << (a_size_i - LDBS)) - BW'(1) : '0;
  assign a_widx = a_address_i[LDB +: MemAddrWidth];
  assign data_ack = op_q[2:1] == 2'b01;
  assign rlast = data_ack ? last_q : '0;
  assign unused_w = ^{a_param_i, a_address_i[LDB-1:0]};
  assign mem_wmask_o = a_mask_i;
  assign mem_wdata_o = a_data_i;
  assign d_opcode_o = state_q == READ ? 3'd1 : state_q != RESP ? 3'd0 :
                      op_q == 3'd5 ? 3'd2 : data_ack ? 3'd1 : 3'd0;
  assign d_param_o = '0;
  assign d_size_o = size_q;
  assign d_source_o = src_q;
  assign d_sink_o = '0;
  assign d_denied_o = den_q;
  assign d_corrupt_o = state_q == READ ? den_q : state_q == RESP && data_ack;
  assign d_data_o = state_q == READ ? fifo_q[rp_q] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      size_q <= '0;
      src_q <= '0;
      base_q <= '0;
      den_q <= 1'b0;
      last_q <= '0;
      beat_q <= '0;
      rsp_q <= '0;
      fifo_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      infl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      size_q <= size_d;
      src_q <= src_d;
      base_q <= base_d;
      den_q <= den_d;
      last_q <= last_d;
      beat_q <= beat_d;
      rsp_q <= rsp_d;
      fifo_q <= fifo_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      infl_q <= infl_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    size_d = size_q;
    src_d = src_q;
    base_d = base_q;
    den_d = den_q;
    last_d = last_q;
    beat_d = beat_q;
    rsp_d = rsp_q;
    fifo_d = fifo_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    infl_d = 1'b0;
    issue = 1'b0;
    pop = 1'b0;
    a_ready_o = 1'b0;
    d_valid_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = base_q + MemAddrWidth'(beat_q);
    case (state_q)
      IDLE: begin
        a_ready_o = 1'b1;
        mem_addr_o = a_widx;
        if (a_valid_i) begin
          op_d = a_opcode_i;
          size_d = a_size_i;
          src_d = a_source_i;
          base_d = a_widx;
          den_d = a_den;
          last_d = a_last;
          beat_d = '0;
          rsp_d = '0;
          if (!a_opcode_i[2]) begin
            mem_req_o = !a_den && !a_corrupt_i;
            mem_we_o = mem_req_o;
            beat_d = a_last == '0 ? '0 : BW'(1);
            state_d = a_last == '0 ? RESP : WRITE;
          end else begin
            state_d = a_opcode_i[1:0] == 2'b00 ? READ : RESP;
          end
        end
      end
      WRITE: begin
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          mem_req_o = !den_q && !a_corrupt_i;
          mem_we_o = mem_req_o;
          beat_d = beat_q == last_q ? '0 : beat_q + BW'(1);
          state_d = beat_q == last_q ? RESP : WRITE;
        end
      end
      READ: begin
        d_valid_o = cnt_q != 2'd0;
        pop = d_valid_o && d_ready_i;
        // a beat popped this cycle frees its slot for the read issued alongside it
        issue = beat_q <= last_q && (3'(cnt_q) + 3'(infl_q)) < (3'd2 + 3'(pop));
        mem_req_o = issue && !den_q;
        beat_d = issue ? beat_q + BW'(1) : beat_q;
        infl_d = issue;
        if (infl_q) begin
          fifo_d[wp_q] = den_q ? '0 : mem_rdata_i;
          wp_d = !wp_q;
        end
        rp_d = pop ? !rp_q : rp_q;
        cnt_d = cnt_q + 2'(infl_q) - 2'(pop);
        rsp_d = pop ? rsp_q + BW'(1) : rsp_q;
        state_d = pop && rsp_q == last_q ? IDLE : READ;
      end
      RESP: begin
        d_valid_o = 1'b1;
        rsp_d = d_ready_i ? rsp_q + BW'(1) : rsp_q;
        state_d = d_ready_i && rsp_q == rlast ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      a_ready_o = 1'b0;
      d_valid_o = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o = 1'b0;
    end
  end
endmodule

// File: doc/tl_sram_adapter.md
Name: tl_sram_adapter

Overview:
- TileLink-UH slave that terminates the A/D channels of a TL link and services them from a single-port synchronous SRAM; sits downstream of the AXI-to-TileLink bridge as the memory endpoint.
- Supports Get, PutFullData, PutPartialData with multibeat bursts. Out-of-window and unsupported requests are answered with denied responses and never touch the SRAM.

Parameters:
- SourceWidth, 1, A/D source ID width
- SinkWidth, 1, D sink width; d_sink is always 0
- AddrWidth, 56, TL address width
- DataWidth, 64, beat width in bits; power of two, at least 32
- SizeWidth, 3, a_size/d_size width
- MemAddrWidth, 10, SRAM word-index width; window = 2^MemAddrWidth * DataWidth/8 bytes
- BaseAddr, 0, window base; aligned to window size

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- a_valid/a_ready  in/out  1  A handshake
- a_opcode  in  3  TL A opcode
- a_param  in  3  ignored
- a_size  in  SizeWidth  log2 transfer bytes
- a_source  in  SourceWidth  request ID
- a_address  in  AddrWidth  byte address, size-aligned
- a_mask  in  DataWidth/8  byte lanes
- a_corrupt  in  1  beat corrupt; suppresses that beat's write
- a_data  in  DataWidth  write data
- d_valid/d_ready  out/in  1  D handshake
- d_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck
- d_param  out  2  always 0
- d_size, d_source  out  SizeWidth/SourceWidth  echoed from request
- d_sink  out  SinkWidth  0
- d_denied, d_corrupt  out  1  error flags
- d_data  out  DataWidth  read data
- mem_req, mem_we  out  1  SRAM enable / write
- mem_addr  out  MemAddrWidth  word index
- mem_wmask  out  DataWidth/8  byte write enables
- mem_wdata  out  DataWidth  write data
- mem_rdata  in  DataWidth  valid in the cycle after a read mem_req

Behaviour:
- Reset: state IDLE; a_ready, d_valid, mem_req, mem_we = 0; all counters and buffer pointers = 0; d_* payload = 0. A reset mid-burst abandons the transaction and does not rewrite the SRAM.
- Beats: nb = max(1, 2^a_size / (DataWidth/8)).
- Word index: ((a_address - BaseAddr) >> log2(DataWidth/8)) + beat, truncated to MemAddrWidth.
- denied = address outside [BaseAddr, BaseAddr + window), or opcode not in {0,1,4,5}.
- States:
  - IDLE: a_ready = 1. On a_valid, latch opcode, size, source, address, denied; set beat = 0. Go to WRITE (0/1/2/3), READ (4), or RESP (5,6,7).
  - WRITE: the first beat is accepted in the IDLE cycle; the same rules apply to every beat. a_ready = 1 while beats remain. Each accepted beat with !denied && !a_corrupt drives mem_req = mem_we = 1 with wmask = a_mask and wdata = a_data in that cycle (no pipeline). After the last beat, go to RESP with a_ready = 0.
  - READ: a_ready = 0. A read is issued (mem_req = 1, mem_we = 0) when beats remain and (buffered + in-flight) < 2. mem_rdata is captured into a 2-entry FIFO one cycle after issue. d_valid = FIFO non-empty. Denied reads issue no mem_req but still enqueue a beat with data 0.
  - Read responses: d_opcode = 1; d_denied = denied; d_corrupt = denied. Return to IDLE when the last beat handshakes.
  - Sustained throughput with d_ready held high is one beat per cycle after 2 cycles of latency.
  - RESP: d_valid = 1. d_opcode = 2 for opcode 5; 1 for opcodes 2/3 (nb data beats of 0, denied and corrupt set); else 0. Hold until d_ready; return to IDLE after the final beat.
- d_* payload is stable while d_valid && !d_ready.
- Exactly one transaction is outstanding; a_ready = 0 from the final request beat until the response completes.
- Beat counter wraps only within nb; the word index wraps modulo 2^MemAddrWidth.

Test Plan:
- PutFullData size 3, addr BaseAddr+0x10, data 0x1122334455667788, mask 0xFF -> one SRAM write at index 2; AccessAck, denied = 0, source echoed.
- Get size 5 at 0x20 after four PutFull beats A..D, d_ready held high -> AccessAckData beats A,B,C,D on 4 consecutive cycles; mem_req on indexes 4..7.
- Same Get with d_ready toggling 1,0,0,1 -> no beat lost or duplicated; at most 2 reads outstanding; payload stable while stalled.
- PutPartialData mask 0x0F over word 0xFFFF... -> read back 0xFFFFFFFF_<new low 32 bits>.
- Get at BaseAddr + window -> no mem_req; nb beats with d_data = 0 and denied = corrupt = 1. ArithmeticData (opcode 2) size 3 -> beat consumed, no write, AccessAckData denied.
- Assert rst mid-Get size 6 -> d_valid and mem_req fall immediately; the next Put is accepted from IDLE.
